// File: rtl/btn_pkg.sv
// Shared state type, default timing constants and width helper for the
// push-button conditioning path.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_t;

    localparam int unsigned STABLE_CYCLES_DEF = 16;
    localparam int unsigned REPEAT_EN_DEF     = 1;
    localparam int unsigned REPEAT_DELAY_DEF  = 64;
    localparam int unsigned REPEAT_PERIOD_DEF = 16;

    function automatic int unsigned max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; both stages
// clear to 0 on synchronous reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_en_conditioner.sv
// Turns a raw bouncing push-button into single-cycle count enables:
// synchronise, debounce press/release, pulse once per press, optional auto-repeat.
module btn_en_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned REPEAT_EN     = REPEAT_EN_DEF,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic en_out,
    output logic btn_level,
    output logic busy
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned REP_W  = $clog2(max(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [REP_W-1:0]  REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0]  REP_NEXT  = REP_W'(REPEAT_PERIOD);
    localparam logic [REP_W-1:0]  REP_MAX   = '1;

    logic btn_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (btn_s)
    );

    btn_state_t        state_d, state_q;
    logic [STAB_W-1:0] stab_d, stab_q;
    logic [REP_W-1:0]  rep_d, rep_q;
    logic              phase_d, phase_q;   // 0: waiting for first repeat, 1: periodic
    logic              en_d, en_q;
    logic              level_d, level_q;
    logic              busy_d, busy_q;
    logic              rep_tick;
    logic [REP_W-1:0]  rep_inc;

    always_comb begin
        state_d  = state_q;
        stab_d   = stab_q;
        rep_d    = rep_q;
        phase_d  = phase_q;
        en_d     = 1'b0;
        rep_tick = 1'b0;
        rep_inc  = '0;

        unique case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d = PRESS_CHK;
                    stab_d  = STAB_ONE;
                end else begin
                    stab_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_d = RELEASED;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = HELD;
                    stab_d  = '0;
                    en_d    = 1'b1;
                    rep_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = REL_CHK;
                    stab_d  = STAB_ONE;
                end else begin
                    rep_tick = 1'b1;
                end
            end
            REL_CHK: begin
                // A bounce back to 1 resumes counting on this same edge.
                if (btn_s) begin
                    state_d  = HELD;
                    stab_d   = '0;
                    rep_tick = 1'b1;
                end else if (stab_q == STAB_LAST) begin
                    state_d = RELEASED;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
        endcase

        if (REPEAT_EN != 0 && rep_tick) begin
            rep_inc = (rep_q == REP_MAX) ? rep_q : rep_q + 1'b1;
            if (rep_inc == (phase_q ? REP_NEXT : REP_FIRST)) begin
                en_d    = 1'b1;
                rep_d   = '0;
                phase_d = 1'b1;
            end else begin
                rep_d = rep_inc;
            end
        end

        if (REPEAT_EN == 0) begin
            rep_d   = '0;
            phase_d = 1'b0;
        end

        level_d = (state_d == HELD) || (state_d == REL_CHK);
        busy_d  = (state_d == PRESS_CHK) || (state_d == REL_CHK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            stab_q  <= '0;
            rep_q   <= '0;
            phase_q <= 1'b0;
            en_q    <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            rep_q   <= rep_d;
            phase_q <= phase_d;
            en_q    <= en_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    assign en_out    = en_q;
    assign btn_level = level_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_btn_en_conditioner.sv
// Bench for btn_en_conditioner: directed press/bounce/repeat/reset scenarios then random
// button traffic, checked against a streak/hold-age reference model.
module tb_btn_en_conditioner;

    localparam int unsigned STABLE = 4;
    localparam int unsigned DELAY  = 8;
    localparam int unsigned PERIOD = 3;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic en0, lvl0, busy0;
    logic en1, lvl1, busy1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: synchroniser pipe, accepted level, opposing-sample
    // streak, and count of held samples since the press.
    logic m_s1, m_s2, m_level;
    int   m_streak, m_age;
    logic m_en0, m_en1;

    always #10 clk = ~clk;

    btn_en_conditioner #(
        .STABLE_CYCLES (STABLE),
        .REPEAT_EN     (0),
        .REPEAT_DELAY  (DELAY),
        .REPEAT_PERIOD (PERIOD)
    ) u_dut_single (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .en_out    (en0),
        .btn_level (lvl0),
        .busy      (busy0)
    );

    btn_en_conditioner #(
        .STABLE_CYCLES (STABLE),
        .REPEAT_EN     (1),
        .REPEAT_DELAY  (DELAY),
        .REPEAT_PERIOD (PERIOD)
    ) u_dut_rep (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .en_out    (en1),
        .btn_level (lvl1),
        .busy      (busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic bs;
        m_en0 = 1'b0;
        m_en1 = 1'b0;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_streak = 0; m_age = 0;
        end else begin
            bs   = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            if (bs != m_level) begin
                m_streak++;
                if (m_streak == int'(STABLE)) begin
                    m_level  = bs;
                    m_streak = 0;
                    if (bs) begin
                        m_en0 = 1'b1;
                        m_en1 = 1'b1;
                        m_age = 0;
                    end
                end
            end else begin
                m_streak = 0;
                if (m_level) begin
                    m_age++;
                    if (m_age >= int'(DELAY) && ((m_age - int'(DELAY)) % int'(PERIOD)) == 0)
                        m_en1 = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle, advance the model on the edge, compare on the falling edge.
    task automatic step(input logic b, input logic r);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        model_edge(b, r);
        @(negedge clk);
        check_eq("en_single",   32'(en0),   32'(m_en0));
        check_eq("level_single", 32'(lvl0), 32'(m_level));
        check_eq("busy_single", 32'(busy0), 32'(m_streak != 0));
        check_eq("en_repeat",   32'(en1),   32'(m_en1));
        check_eq("level_repeat", 32'(lvl1), 32'(m_level));
        check_eq("busy_repeat", 32'(busy1), 32'(m_streak != 0));
    endtask

    initial begin
        int exp_rep[7];
        int p0[$];
        int p1[$];
        int first_edge;
        exp_rep = '{6, 14, 17, 20, 23, 26, 29};
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_streak = 0; m_age = 0;
        m_en0 = 1'b0; m_en1 = 1'b0;
        btn_in = 1'b0;
        rst    = 1'b1;

        // Reset held with the button pressed, then a 30-cycle clean hold.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        first_edge = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b0);
            if (en0) p0.push_back(i);
            if (en1) p1.push_back(i);
            if (lvl0 && first_edge < 0) first_edge = i;
        end
        check_eq("single_pulse_count", 32'(p0.size()), 32'd1);
        if (p0.size() > 0) check_eq("single_pulse_edge", 32'(p0[0]), 32'd6);
        check_eq("level_rise_edge", 32'(first_edge), 32'd6);
        check_eq("repeat_pulse_count", 32'(p1.size()), 32'd7);
        for (int k = 0; k < p1.size() && k < 7; k++)
            check_eq("repeat_pulse_edge", 32'(p1[k]), 32'(exp_rep[k]));

        // Clean release: level drops on the 6th edge.
        first_edge = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0);
            if (!lvl0 && first_edge < 0) first_edge = i;
        end
        check_eq("level_fall_edge", 32'(first_edge), 32'd6);

        // Bounce 1,0,1,0,1 then steady 1: one pulse 6 edges after the last rise.
        p0.delete();
        for (int i = 1; i <= 17; i++) begin
            step((i >= 5) ? 1'b1 : ((i % 2) == 1), 1'b0);
            if (en0) p0.push_back(i);
        end
        check_eq("bounce_pulse_count", 32'(p0.size()), 32'd1);
        if (p0.size() > 0) check_eq("bounce_pulse_edge", 32'(p0[0]), 32'd10);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

        // Short drop while held: level must stay up, repeats shift.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            check_eq("level_through_drop", 32'(lvl1), 32'd1);
        end
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

        // Reset mid-qualification: the next press pays full latency.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_eq("busy_after_reset", 32'(busy0), 32'd0);
        first_edge = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0);
            if (en0 && first_edge < 0) first_edge = i;
        end
        check_eq("post_reset_latency", 32'(first_edge), 32'd6);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

        // Random button traffic with occasional resets.
        for (int seg = 0; seg < 160; seg++) begin
            int unsigned r;
            int unsigned len;
            logic lvl;
            r   = $urandom_range(0, 19);
            lvl = 1'($urandom_range(0, 1));
            len = (r < 7) ? $urandom_range(1, 3) : $urandom_range(4, 30);
            if (r == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 2)); i++) step(lvl, 1'b1);
            end else begin
                for (int i = 0; i < int'(len); i++) step(lvl, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
